servo_pwm_gen: RTL and testbench
================================

Name: servo_pwm_gen

Overview:
- Back end of the servo value path: consumes the 20-bit pulse-width constants produced by the angle decoding logic (x, y, fire) and drives three servo PWM pins.
- One shared frame counter; per-channel pulse high-time in clocks.
- Values are double-buffered: captured on a load strobe into pending registers, then committed at the frame boundary, so pulses never glitch mid-frame.

Parameters:
- PERIOD, 1000000, frame length in clocks (20 ms at 50 MHz); legal range 2..2^20.
- MAX_PULSE, 125000, saturation limit for any channel's high-time in clocks; must be < PERIOD.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  capture strobe; samples x_value/y_value/fire_value this cycle
- x_value  in  20  pan servo high-time, clocks
- y_value  in  20  tilt servo high-time, clocks
- fire_value  in  20  trigger servo high-time, clocks; 0 = no pulse
- pwm_x  out  1  pan servo PWM
- pwm_y  out  1  tilt servo PWM
- pwm_fire  out  1  trigger servo PWM
- frame_tick  out  1  one-cycle pulse, first cycle of each frame
- upd_ack  out  1  one-cycle pulse when a pending load is committed

Behaviour:
- Clock is one domain; reset_n is asynchronous and active-low (assert async, release sync to clk).
- Reset values: cnt=0, pending/active regs=0, pend_flag=0, pwm_x/pwm_y/pwm_fire=0, frame_tick=0, upd_ack=0. Reset mid-frame forces all outputs low immediately.
- Frame counter cnt, 20 bit: counts 0..PERIOD-1, wraps to 0. The first cycle after reset release has cnt=0.
- Load capture:
  - load=1 registers sat(v) = min(v, MAX_PULSE) for each channel into pending regs and sets pend_flag.
  - Back-to-back loads overwrite; the last load before commit wins.
- Commit:
  - On the clock edge where cnt wraps PERIOD-1 -> 0, if pend_flag=1 then active <= pending, pend_flag <= 0, and upd_ack=1 during the cnt=0 cycle.
  - If load=1 on the cnt=PERIOD-1 cycle, the sampled inputs bypass the pending regs and commit directly at that wrap (upd_ack=1). pend_flag ends 0.
  - A load on the cnt=0 cycle or later waits for the next wrap.
- Frame tick: frame_tick=1 exactly during cycles with cnt=0.
- PWM outputs:
  - Each output is registered.
  - pwm_ch at cycle t+1 = (cnt(t) < active_ch(t)), using the value already committed for the frame.
  - Result: high for exactly active_ch clocks, rising one clock after the frame_tick cycle.
  - active=0 keeps the pin low for the whole frame; active=MAX_PULSE gives MAX_PULSE high clocks.
- Arithmetic: unsigned 20-bit compares only; saturation is applied at capture, never at compare.
- Channels are independent; all share cnt, so their rising edges are aligned.

Test Plan:
- Reset then idle, PERIOD=100, MAX_PULSE=40 -> all pwm low forever; frame_tick high at cnt=0 every 100 clocks; upd_ack never asserted.
- load x=10, y=25, fire=0 at cnt=50 -> no pwm change until wrap; upd_ack at next cnt=0; pwm_x high 10 clocks, pwm_y high 25 clocks, each starting at cnt=1 output cycle; pwm_fire stays low.
- load x=200 (over limit) -> pwm_x high exactly 40 clocks per frame.
- load x=5 at cnt=30, then x=15 at cnt=60 -> after wrap pwm_x high 15 clocks; one upd_ack.
- load x=20 on the cnt=99 cycle -> committed at this wrap, pwm_x high 20 clocks in the immediately following frame, upd_ack=1 at cnt=0.
- Assert reset_n low mid-pulse at cnt=5 with x=30 active -> pwm_x drops low asynchronously; after release, cnt restarts at 0 and active=0, so pwm_x stays low until a new load commits.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Three-channel servo PWM generator: one shared frame counter, per-channel
// double-buffered pulse widths committed only at the frame boundary.
module servo_pwm_gen #(
   parameter int unsigned PERIOD    = 1000000,
   parameter int unsigned MAX_PULSE = 125000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [19:0] x_value,
   input  logic [19:0] y_value,
   input  logic [19:0] fire_value,
   output logic        pwm_x,
   output logic        pwm_y,
   output logic        pwm_fire,
   output logic        frame_tick,
   output logic        upd_ack
);

   localparam logic [19:0] LAST  = 20'(PERIOD - 1);
   localparam logic [19:0] LIMIT = 20'(MAX_PULSE);

   logic [19:0] cnt_q, cnt_d;
   logic [19:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_f_q, pend_f_d;
   logic [19:0] act_x_q, act_x_d, act_y_q, act_y_d, act_f_q, act_f_d;
   logic        pend_flag_q, pend_flag_d;
   logic        pwm_x_q, pwm_x_d, pwm_y_q, pwm_y_d, pwm_f_q, pwm_f_d;
   logic        tick_q, tick_d;
   logic        ack_q, ack_d;
   logic        wrap;

   function automatic logic [19:0] sat(input logic [19:0] v);
      return (v > LIMIT) ? LIMIT : v;
   endfunction

   always_comb begin
      wrap  = (cnt_q == LAST);
      cnt_d = wrap ? '0 : cnt_q + 20'd1;

      pend_x_d = load ? sat(x_value)    : pend_x_q;
      pend_y_d = load ? sat(y_value)    : pend_y_q;
      pend_f_d = load ? sat(fire_value) : pend_f_q;
      pend_flag_d = wrap ? 1'b0 : (load | pend_flag_q);

      act_x_d = act_x_q;
      act_y_d = act_y_q;
      act_f_d = act_f_q;
      // A load on the last cycle of the frame skips the pending stage.
      if (wrap) begin
         if (load) begin
            act_x_d = sat(x_value);
            act_y_d = sat(y_value);
            act_f_d = sat(fire_value);
         end else if (pend_flag_q) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
            act_f_d = pend_f_q;
         end
      end

      ack_d  = wrap & (load | pend_flag_q);
      tick_d = wrap;

      pwm_x_d = (cnt_q < act_x_q);
      pwm_y_d = (cnt_q < act_y_q);
      pwm_f_d = (cnt_q < act_f_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_f_q    <= '0;
         pend_flag_q <= 1'b0;
         act_x_q     <= '0;
         act_y_q     <= '0;
         act_f_q     <= '0;
         pwm_x_q     <= 1'b0;
         pwm_y_q     <= 1'b0;
         pwm_f_q     <= 1'b0;
         tick_q      <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_f_q    <= pend_f_d;
         pend_flag_q <= pend_flag_d;
         act_x_q     <= act_x_d;
         act_y_q     <= act_y_d;
         act_f_q     <= act_f_d;
         pwm_x_q     <= pwm_x_d;
         pwm_y_q     <= pwm_y_d;
         pwm_f_q     <= pwm_f_d;
         tick_q      <= tick_d;
         ack_q       <= ack_d;
      end
   end

   assign pwm_x      = pwm_x_q;
   assign pwm_y      = pwm_y_q;
   assign pwm_fire   = pwm_f_q;
   assign frame_tick = tick_q;
   assign upd_ack    = ack_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with PERIOD=100, MAX_PULSE=40; the bench
// tracks the frame position itself and measures pulse widths per frame.
module tb_servo_pwm_gen;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        load = 1'b0;
   logic [19:0] x_value = '0;
   logic [19:0] y_value = '0;
   logic [19:0] fire_value = '0;
   logic        pwm_x, pwm_y, pwm_fire, frame_tick, upd_ack;

   int total = 0;
   int bad = 0;
   int ref_cnt = 0;

   // per-window measurement results
   int m_nx, m_ny, m_nf, m_xfirst, m_xlast, m_yfirst, m_ylast;
   int m_ticks, m_tick_off, m_acks, m_ack_off;

   servo_pwm_gen #(.PERIOD(100), .MAX_PULSE(40)) dut (
      .clk(clk), .reset_n(reset_n), .load(load),
      .x_value(x_value), .y_value(y_value), .fire_value(fire_value),
      .pwm_x(pwm_x), .pwm_y(pwm_y), .pwm_fire(pwm_fire),
      .frame_tick(frame_tick), .upd_ack(upd_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      ref_cnt = (ref_cnt + 1) % 100;
   endtask

   task automatic goto(input int c);
      for (int i = 0; i < 100 && ref_cnt != c; i++) step();
   endtask

   task automatic do_load(input int x, input int y, input int f);
      load = 1'b1;
      x_value = 20'(x);
      y_value = 20'(y);
      fire_value = 20'(f);
      step();
      load = 1'b0;
   endtask

   // Sample n consecutive cycles starting at the current one.
   task automatic measure(input int n);
      m_nx = 0; m_ny = 0; m_nf = 0;
      m_xfirst = -1; m_xlast = -1; m_yfirst = -1; m_ylast = -1;
      m_ticks = 0; m_tick_off = 0; m_acks = 0; m_ack_off = 0;
      for (int i = 0; i < n; i++) begin
         if (pwm_x === 1'b1) begin
            m_nx++;
            if (m_xfirst < 0) m_xfirst = ref_cnt;
            m_xlast = ref_cnt;
         end
         if (pwm_y === 1'b1) begin
            m_ny++;
            if (m_yfirst < 0) m_yfirst = ref_cnt;
            m_ylast = ref_cnt;
         end
         if (pwm_fire === 1'b1) m_nf++;
         if (frame_tick === 1'b1) begin
            m_ticks++;
            if (ref_cnt != 0) m_tick_off++;
         end
         if (upd_ack === 1'b1) begin
            m_acks++;
            if (ref_cnt != 0) m_ack_off++;
         end
         step();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({pwm_x, pwm_y, pwm_fire, frame_tick, upd_ack} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {pwm_x, pwm_y, pwm_fire, frame_tick, upd_ack});
      end
      reset_n = 1'b1;
      ref_cnt = 0;
      step();
      total++;
      if ({pwm_x, pwm_y, pwm_fire, upd_ack} !== 4'b0) begin
         bad++;
         $display("FAIL after_release: got %b want 0000", {pwm_x, pwm_y, pwm_fire, upd_ack});
      end
   endtask

   task automatic test_idle();
      goto(0);
      for (int f = 0; f < 2; f++) begin
         measure(100);
         total++;
         if (m_nx + m_ny + m_nf != 0) begin
            bad++;
            $display("FAIL idle_pwm: got %0d high cycles want 0", m_nx + m_ny + m_nf);
         end
         total++;
         if (m_ticks != 1 || m_tick_off != 0) begin
            bad++;
            $display("FAIL idle_tick: got ticks=%0d off=%0d want ticks=1 off=0", m_ticks, m_tick_off);
         end
         total++;
         if (m_acks != 0) begin
            bad++;
            $display("FAIL idle_ack: got %0d want 0", m_acks);
         end
      end
   endtask

   task automatic test_load_basic();
      goto(50);
      do_load(10, 25, 0);
      measure(49);
      total++;
      if (m_nx + m_ny + m_nf != 0 || m_acks != 0) begin
         bad++;
         $display("FAIL basic_pre_wrap: got high=%0d acks=%0d want 0 0", m_nx + m_ny + m_nf, m_acks);
      end
      measure(100);
      total++;
      if (m_nx != 10 || m_xfirst != 1 || m_xlast != 10) begin
         bad++;
         $display("FAIL basic_x: got n=%0d first=%0d last=%0d want 10 1 10", m_nx, m_xfirst, m_xlast);
      end
      total++;
      if (m_ny != 25 || m_yfirst != 1 || m_ylast != 25) begin
         bad++;
         $display("FAIL basic_y: got n=%0d first=%0d last=%0d want 25 1 25", m_ny, m_yfirst, m_ylast);
      end
      total++;
      if (m_nf != 0) begin
         bad++;
         $display("FAIL basic_fire: got %0d want 0", m_nf);
      end
      total++;
      if (m_acks != 1 || m_ack_off != 0) begin
         bad++;
         $display("FAIL basic_ack: got acks=%0d off=%0d want 1 0", m_acks, m_ack_off);
      end
      measure(100);
      total++;
      if (m_nx != 10 || m_ny != 25 || m_acks != 0) begin
         bad++;
         $display("FAIL basic_hold: got x=%0d y=%0d acks=%0d want 10 25 0", m_nx, m_ny, m_acks);
      end
   endtask

   task automatic test_saturate();
      goto(20);
      do_load(200, 40, 1);
      goto(0);
      measure(100);
      total++;
      if (m_nx != 40 || m_xlast != 40) begin
         bad++;
         $display("FAIL sat_x: got n=%0d last=%0d want 40 40", m_nx, m_xlast);
      end
      total++;
      if (m_ny != 40) begin
         bad++;
         $display("FAIL sat_y_at_limit: got %0d want 40", m_ny);
      end
      total++;
      if (m_nf != 1) begin
         bad++;
         $display("FAIL sat_fire_one: got %0d want 1", m_nf);
      end
   endtask

   task automatic test_back_to_back();
      goto(30);
      do_load(5, 0, 0);
      goto(60);
      do_load(15, 0, 0);
      goto(0);
      measure(100);
      total++;
      if (m_nx != 15 || m_acks != 1) begin
         bad++;
         $display("FAIL b2b_last_wins: got x=%0d acks=%0d want 15 1", m_nx, m_acks);
      end
      total++;
      if (m_ny != 0 || m_nf != 0) begin
         bad++;
         $display("FAIL b2b_other_ch: got y=%0d f=%0d want 0 0", m_ny, m_nf);
      end
      goto(70);
      do_load(7, 3, 0);
      do_load(9, 4, 0);
      goto(0);
      measure(100);
      total++;
      if (m_nx != 9 || m_ny != 4 || m_acks != 1) begin
         bad++;
         $display("FAIL b2b_consecutive: got x=%0d y=%0d acks=%0d want 9 4 1", m_nx, m_ny, m_acks);
      end
   endtask

   task automatic test_wrap_load();
      goto(99);
      do_load(20, 0, 0);
      measure(100);
      total++;
      if (m_nx != 20 || m_acks != 1 || m_ack_off != 0) begin
         bad++;
         $display("FAIL wrap_bypass: got x=%0d acks=%0d off=%0d want 20 1 0", m_nx, m_acks, m_ack_off);
      end
      measure(100);
      total++;
      if (m_nx != 20 || m_acks != 0) begin
         bad++;
         $display("FAIL wrap_no_repeat_ack: got x=%0d acks=%0d want 20 0", m_nx, m_acks);
      end
   endtask

   task automatic test_load_at_zero();
      goto(0);
      do_load(33, 0, 0);
      measure(99);
      total++;
      if (m_nx != 20 || m_acks != 0) begin
         bad++;
         $display("FAIL zero_load_deferred: got x=%0d acks=%0d want 20 0", m_nx, m_acks);
      end
      measure(100);
      total++;
      if (m_nx != 33 || m_acks != 1) begin
         bad++;
         $display("FAIL zero_load_commit: got x=%0d acks=%0d want 33 1", m_nx, m_acks);
      end
   endtask

   task automatic test_reset_mid();
      goto(50);
      do_load(30, 0, 0);
      goto(5);
      total++;
      if (pwm_x !== 1'b1) begin
         bad++;
         $display("FAIL mid_pulse_high: got %b want 1", pwm_x);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (pwm_x !== 1'b0) begin
         bad++;
         $display("FAIL async_reset_drop: got %b want 0", pwm_x);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      ref_cnt = 0;
      measure(200);
      total++;
      if (m_nx != 0 || m_acks != 0) begin
         bad++;
         $display("FAIL post_reset_cleared: got x=%0d acks=%0d want 0 0", m_nx, m_acks);
      end
      total++;
      if (m_ticks != 1 || m_tick_off != 0) begin
         bad++;
         $display("FAIL post_reset_tick: got ticks=%0d off=%0d want 1 0", m_ticks, m_tick_off);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_load_basic();
      test_saturate();
      test_back_to_back();
      test_wrap_load();
      test_load_at_zero();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
